// File: rtl/mips_lite_pkg.sv
// Shared definitions for the MIPS-lite pipeline sequencer.
//  - opcode constants
//  - sb_slot_t   : one in-flight scoreboard entry {vld, dst, is_ld}
//  - hc_state_t  : sequencer FSM states
//  - dec_t       : register usage of one instruction
//  - decode_regs : instruction word -> dec_t
package mips_lite_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_MUL  = 6'd4;
    localparam logic [5:0] OP_XORI = 6'd11;
    localparam logic [5:0] OP_LDW  = 6'd12;
    localparam logic [5:0] OP_STW  = 6'd13;
    localparam logic [5:0] OP_BZ   = 6'd14;
    localparam logic [5:0] OP_BEQ  = 6'd15;
    localparam logic [5:0] OP_JR   = 6'd16;
    localparam logic [5:0] OP_HALT = 6'd17;

    typedef struct packed {
        logic       vld;
        logic [4:0] dst;
        logic       is_ld;
    } sb_slot_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } hc_state_t;

    typedef struct packed {
        logic       has_dst;
        logic [4:0] dst;
        logic       use_rs;
        logic       use_rt;
        logic       is_ld;
        logic       is_ctl;
        logic       is_halt;
    } dec_t;

    function automatic dec_t decode_regs(input logic [31:0] inst);
        dec_t       d;
        logic [5:0] opc;
        opc = inst[31:26];
        d   = '0;
        if (opc <= OP_XORI) begin
            // ALU ops: even opcodes are R-type, odd opcodes are immediates
            d.has_dst = 1'b1;
            d.use_rs  = 1'b1;
            if (!opc[0]) begin
                d.dst    = inst[15:11];
                d.use_rt = 1'b1;
            end else begin
                d.dst    = inst[20:16];
            end
        end else begin
            case (opc)
                OP_LDW: begin
                    d.has_dst = 1'b1;
                    d.dst     = inst[20:16];
                    d.use_rs  = 1'b1;
                    d.is_ld   = 1'b1;
                end
                OP_STW: begin
                    d.use_rs = 1'b1;
                    d.use_rt = 1'b1;
                end
                OP_BZ, OP_JR: begin
                    d.use_rs = 1'b1;
                    d.is_ctl = 1'b1;
                end
                OP_BEQ: begin
                    d.use_rs = 1'b1;
                    d.use_rt = 1'b1;
                    d.is_ctl = 1'b1;
                end
                OP_HALT: d.is_halt = 1'b1;
                default: ;
            endcase
        end
        // R0 is hard-wired zero, so writing it creates no dependency
        if (d.dst == 5'd0)
            d.has_dst = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// In-flight destination tracker: EX and MEM slots shifting every cycle, plus
// the RAW match against the sources of the instruction in ID.
// Ports:
//  clk, rst        clock, async active-high reset
//  i_issue         ID instruction enters EX this cycle (otherwise a bubble)
//  i_has_dst/i_dst/i_is_ld   destination info of the ID instruction
//  i_id_valid, i_use_rs, i_use_rt, i_rs, i_rt   sources of the ID instruction
//  o_raw_hazard    ID instruction must wait
//  o_sb_empty      no valid slot in flight
module hz_scoreboard #(
    parameter int unsigned FWD_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_issue,
    input  logic       i_has_dst,
    input  logic [4:0] i_dst,
    input  logic       i_is_ld,
    input  logic       i_id_valid,
    input  logic       i_use_rs,
    input  logic       i_use_rt,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    output logic       o_raw_hazard,
    output logic       o_sb_empty
);
    import mips_lite_pkg::*;

    sb_slot_t r_ex, r_mem;
    sb_slot_t w_ex_next;
    logic     w_ex_hit, w_mem_hit;

    always_comb begin
        w_ex_next       = '0;
        w_ex_next.vld   = i_issue && i_has_dst;
        w_ex_next.dst   = i_dst;
        w_ex_next.is_ld = i_is_ld;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
        end else begin
            r_mem <= r_ex;
            r_ex  <= w_ex_next;
        end
    end

    assign w_ex_hit  = r_ex.vld  && ((i_use_rs && i_rs == r_ex.dst)  || (i_use_rt && i_rt == r_ex.dst));
    assign w_mem_hit = r_mem.vld && ((i_use_rs && i_rs == r_mem.dst) || (i_use_rt && i_rt == r_mem.dst));

    // With forwarding only a load result is still unavailable one stage later;
    // register file write-before-read hides WB, so no third slot is needed.
    assign o_raw_hazard = i_id_valid &&
                          ((FWD_EN != 0) ? (w_ex_hit && r_ex.is_ld) : (w_ex_hit || w_mem_hit));
    assign o_sb_empty   = !r_ex.vld && !r_mem.vld;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS-lite core: fetch hold, ID/EX
// bubbles, wrong-path flush after a taken branch, drain-to-halt.
// Ports:
//  clk, rst               clock, async active-high reset
//  id_valid, id_inst      instruction currently in ID
//  br_resolve, br_taken   EX-stage branch outcome pulse
//  stall_if, bubble_ex, flush_id, halted   combinational sequencing outputs
//  stall_cnt, flush_cnt   saturating performance counters
module hazard_ctrl #(
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             br_resolve,
    input  logic             br_taken,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import mips_lite_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    dec_t             w_dec;
    hc_state_t        r_state;
    logic             r_drain_wb;
    logic             w_hazard, w_sb_empty, w_issue, w_halt_go;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    assign w_dec = decode_regs(id_inst);

    hz_scoreboard #(.FWD_EN(FWD_EN)) u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_issue      (w_issue),
        .i_has_dst    (w_dec.has_dst),
        .i_dst        (w_dec.dst),
        .i_is_ld      (w_dec.is_ld),
        .i_id_valid   (id_valid),
        .i_use_rs     (w_dec.use_rs),
        .i_use_rt     (w_dec.use_rt),
        .i_rs         (id_inst[25:21]),
        .i_rt         (id_inst[20:16]),
        .o_raw_hazard (w_hazard),
        .o_sb_empty   (w_sb_empty)
    );

    // HALT never issues; it holds in ID while the pipe drains
    assign w_halt_go = (r_state == ST_RUN) && !w_hazard && id_valid && w_dec.is_halt;

    always_comb begin
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        halted    = 1'b0;
        w_issue   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_hazard || w_halt_go) begin
                    stall_if  = 1'b1;
                    bubble_ex = 1'b1;
                end else begin
                    w_issue = id_valid;
                end
            end
            ST_BR_WAIT: begin
                // fetch is released in the resolve cycle so it can follow the redirect
                bubble_ex = 1'b1;
                stall_if  = !br_resolve;
                flush_id  = br_resolve && br_taken;
            end
            ST_DRAIN: begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end
            ST_HALTED: begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
                halted    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_drain_wb <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_drain_wb <= 1'b0;
                    if (w_issue && w_dec.is_ctl)
                        r_state <= ST_BR_WAIT;
                    else if (w_halt_go)
                        r_state <= ST_DRAIN;
                end
                ST_BR_WAIT: begin
                    if (br_resolve)
                        r_state <= ST_RUN;
                end
                ST_DRAIN: begin
                    // one extra cycle after EX/MEM empty lets the last WB land
                    if (w_sb_empty) begin
                        if (r_drain_wb)
                            r_state <= ST_HALTED;
                        else
                            r_drain_wb <= 1'b1;
                    end
                end
                ST_HALTED: ;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state == ST_RUN && w_hazard && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (r_state == ST_BR_WAIT && br_resolve && br_taken && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
